// File: rtl/bus_dma_initiator.sv
// Word-copy bus initiator: reads one 32-bit word, writes it to the destination, and repeats
// until the latched count is reached, abort is seen at an access boundary, or an access times out.
module bus_dma_initiator #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_word_count,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [LEN_W-1:0] o_words_done,
  output logic [31:0]      o_bus_addr,
  output logic [31:0]      o_bus_wdata,
  output logic [3:0]       o_bus_wmask,
  output logic             o_bus_wen,
  output logic             o_bus_ren,
  input  logic [31:0]      i_bus_rdata,
  input  logic             i_bus_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (TIMEOUT != 0);

  logic [1:0]        r_state;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [LEN_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [LEN_W-1:0]  r_words_done;
  logic [31:0]       r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wmask;
  logic              r_bus_wen;
  logic              r_bus_ren;

  logic              w_misaligned;
  logic              w_timeout;
  logic [LEN_W-1:0]  w_words_inc;
  logic              w_last;

  // Start qualification, timeout detection and word-count termination.
  always_comb begin
    w_misaligned = (i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00);
    w_timeout    = TIMEOUT_EN && !i_bus_ready && (r_wait == WAIT_LAST);
    w_words_inc  = r_words_done + {{(LEN_W-1){1'b0}}, 1'b1};
    w_last       = (w_words_inc == r_count);
  end

  // Transfer sequencer; bus outputs are registered and change together with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_src        <= 32'd0;
      r_dst        <= 32'd0;
      r_count      <= '0;
      r_wait       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_words_done <= '0;
      r_bus_addr   <= 32'd0;
      r_bus_wdata  <= 32'd0;
      r_bus_wmask  <= 4'b0000;
      r_bus_wen    <= 1'b0;
      r_bus_ren    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_error      <= w_misaligned;
            r_words_done <= '0;
            r_src        <= i_src_addr;
            r_dst        <= i_dst_addr;
            r_count      <= i_word_count;
            r_wait       <= '0;
            if (w_misaligned || (i_word_count == '0)) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state    <= RD;
              r_busy     <= 1'b1;
              r_bus_ren  <= 1'b1;
              r_bus_addr <= i_src_addr;
            end
          end
        end
        RD: begin
          if (i_bus_ready) begin
            r_bus_ren <= 1'b0;
            r_wait    <= '0;
            if (i_abort) begin
              r_state    <= FIN;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_bus_addr <= 32'd0;
            end else begin
              r_state     <= WR;
              r_bus_wen   <= 1'b1;
              r_bus_wmask <= 4'b1111;
              r_bus_addr  <= r_dst;
              r_bus_wdata <= i_bus_rdata;
            end
          end else if (w_timeout) begin
            r_error    <= 1'b1;
            r_bus_ren  <= 1'b0;
            r_state    <= FIN;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_bus_addr <= 32'd0;
          end else begin
            r_wait <= r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        WR: begin
          if (i_bus_ready) begin
            r_bus_wen    <= 1'b0;
            r_bus_wmask  <= 4'b0000;
            r_words_done <= w_words_inc;
            r_src        <= r_src + 32'd4;
            r_dst        <= r_dst + 32'd4;
            r_wait       <= '0;
            if (w_last || i_abort) begin
              r_state     <= FIN;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_bus_addr  <= 32'd0;
              r_bus_wdata <= 32'd0;
            end else begin
              r_state    <= RD;
              r_bus_ren  <= 1'b1;
              r_bus_addr <= r_src + 32'd4;
            end
          end else if (w_timeout) begin
            r_error     <= 1'b1;
            r_bus_wen   <= 1'b0;
            r_bus_wmask <= 4'b0000;
            r_state     <= FIN;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
          end else begin
            r_wait <= r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_words_done = r_words_done;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_wdata  = r_bus_wdata;
  assign o_bus_wmask  = r_bus_wmask;
  assign o_bus_wen    = r_bus_wen;
  assign o_bus_ren    = r_bus_ren;

endmodule

// File: tb/tb_bus_dma_initiator.sv
// Bench for bus_dma_initiator: a memory-backed responder with programmable stalls, and a
// reference model that derives the expected write stream from source/destination/count.
module tb_bus_dma_initiator;
  localparam int LEN_W = 16;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] word_count;
  logic             abort;
  logic             busy;
  logic             done;
  logic             error;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic [3:0]       bus_wmask;
  logic             bus_wen;
  logic             bus_ren;
  logic [31:0]      bus_rdata;
  logic             bus_ready;

  int checks = 0;
  int errors = 0;

  // responder configuration: 0 always ready, 1 two-cycle stall, 2 random 0..2 stall, 3 stuck low
  int          rdy_mode = 0;
  bit          use_hash = 1'b0;
  logic [31:0] seed = 32'd0;
  int          viol = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];

  int         wcnt = 0;
  int         tgt = 0;
  bit         last_acc = 1'b0;
  bit         prev_stall = 1'b0;
  bit         req;
  logic [69:0] snap = '0;

  always #5 clk = ~clk;

  bus_dma_initiator #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_src_addr(src_addr), .i_dst_addr(dst_addr),
    .i_word_count(word_count), .i_abort(abort), .o_busy(busy), .o_done(done), .o_error(error),
    .o_words_done(words_done), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .o_bus_wmask(bus_wmask), .o_bus_wen(bus_wen), .o_bus_ren(bus_ren),
    .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready)
  );

  // source memory contents as a pure function of the byte address
  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (use_hash) return (a * 32'h9E37_79B1) ^ seed;
    else return 32'hA + ((a - 32'h1000) >> 2);
  endfunction

  assign bus_rdata = use_hash ? ((bus_addr * 32'h9E37_79B1) ^ seed) : (32'hA + ((bus_addr - 32'h1000) >> 2));

  // responder and protocol monitor, evaluated mid-cycle
  initial begin
    bus_ready = 1'b1;
    forever begin
      @(negedge clk);
      req = bus_ren | bus_wen;
      if (!req || last_acc) wcnt = 0;
      if (req && wcnt == 0) tgt = (rdy_mode == 1) ? 2 : (rdy_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (rdy_mode == 3) bus_ready = 1'b0;
      else bus_ready = !req || (wcnt >= tgt);
      if (req) wcnt++;
      if (bus_ren && bus_wen) viol++;
      if (bus_wmask !== (bus_wen ? 4'hF : 4'h0)) viol++;
      if (bus_addr[1:0] !== 2'b00) viol++;
      if (prev_stall && req && ({bus_addr, bus_wdata, bus_ren, bus_wen, bus_wmask} !== snap)) viol++;
      prev_stall = req && !bus_ready;
      snap = {bus_addr, bus_wdata, bus_ren, bus_wen, bus_wmask};
      if (bus_wen && bus_ready) begin
        wr_addr_q.push_back(bus_addr);
        wr_data_q.push_back(bus_wdata);
      end
      if (bus_ren && bus_ready) rd_addr_q.push_back(bus_addr);
      last_acc = req && bus_ready;
    end
  end

  // Launch one copy and follow it to done; cycle 1 is the cycle after the accepting edge.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int abort_rd,
                          input bit restart, output int done_cyc, output logic [31:0] ren_tr,
                          output logic [31:0] wen_tr);
    int rd_seen = 0;
    bit prev_ren = 1'b0;
    done_cyc = -1;
    ren_tr = '0;
    wen_tr = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    word_count = LEN_W'(n);
    start = 1'b1;
    for (int c = 1; c < 400 && done_cyc < 0; c++) begin
      @(negedge clk);
      start = restart && (c == 2);
      if (c == 1) begin
        src_addr = $urandom;
        dst_addr = $urandom;
        word_count = LEN_W'($urandom);
      end
      if (c < 32) begin
        ren_tr[c] = bus_ren;
        wen_tr[c] = bus_wen;
      end
      if (bus_ren && !prev_ren) rd_seen++;
      prev_ren = bus_ren;
      if (abort_rd > 0 && rd_seen == abort_rd) abort = 1'b1;
      if (done) done_cyc = c;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; word_count = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status busy/done/error=%b expected 000", {busy, done, error}); end
    checks++; if (words_done !== '0) begin errors++; $display("FAIL reset_words_done got %0d expected 0", words_done); end
    checks++; if ({bus_ren, bus_wen, bus_wmask} !== 6'd0) begin errors++; $display("FAIL reset_bus_ctl got %b expected 000000", {bus_ren, bus_wen, bus_wmask}); end
    checks++; if ({bus_addr, bus_wdata} !== 64'd0) begin errors++; $display("FAIL reset_bus_data addr=%h wdata=%h expected 0", bus_addr, bus_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc; logic [31:0] rt, wt;
    rdy_mode = 0; use_hash = 1'b0; viol = 0;
    run_copy(32'h1000, 32'h2000, 3, 0, 1'b0, dc, rt, wt);
    checks++; if (dc !== 7) begin errors++; $display("FAIL basic_done_cycle got %0d expected 7", dc); end
    checks++; if (rt[15:0] !== 16'h002A) begin errors++; $display("FAIL basic_read_cycles got %h expected 002a", rt[15:0]); end
    checks++; if (wt[15:0] !== 16'h0054) begin errors++; $display("FAIL basic_write_cycles got %h expected 0054", wt[15:0]); end
    checks++; if (wr_addr_q.size() !== 3) begin errors++; $display("FAIL basic_write_count got %0d expected 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'h2000 + 32'(4 * i) || wr_data_q[i] !== 32'hA + 32'(i))
        begin errors++; $display("FAIL basic_write%0d got %h<=%h expected %h<=%h", i, wr_addr_q[i], wr_data_q[i], 32'h2000 + 32'(4 * i), 32'hA + 32'(i)); end
    end
    checks++; if (words_done !== 16'd3 || error !== 1'b0) begin errors++; $display("FAIL basic_final words_done=%0d error=%b expected 3/0", words_done, error); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL basic_protocol got %0d violations expected 0", viol); end
  endtask

  task automatic test_stall();
    int dc; logic [31:0] rt, wt;
    rdy_mode = 1; use_hash = 1'b1; seed = $urandom; viol = 0;
    run_copy(32'h3000, 32'h4000, 2, 0, 1'b0, dc, rt, wt);
    checks++; if (dc !== 13) begin errors++; $display("FAIL stall_done_cycle got %0d expected 13", dc); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL stall_stability got %0d violations expected 0", viol); end
    checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL stall_write_count got %0d expected 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'h4000 + 32'(4 * i) || wr_data_q[i] !== src_word(32'h3000 + 32'(4 * i)))
        begin errors++; $display("FAIL stall_write%0d got %h<=%h expected %h<=%h", i, wr_addr_q[i], wr_data_q[i], 32'h4000 + 32'(4 * i), src_word(32'h3000 + 32'(4 * i))); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_timeout();
    int dc; logic [31:0] rt, wt;
    rdy_mode = 3;
    run_copy(32'h1000, 32'h2000, 3, 0, 1'b0, dc, rt, wt);
    rdy_mode = 0;
    checks++; if (rt[15:0] !== 16'h001E) begin errors++; $display("FAIL timeout_read_hold got %h expected 001e", rt[15:0]); end
    checks++; if (wt !== 32'd0 || wr_addr_q.size() !== 0) begin errors++; $display("FAIL timeout_no_write got trace %h writes %0d expected 0/0", wt, wr_addr_q.size()); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL timeout_done_cycle got %0d expected 5", dc); end
    checks++; if (error !== 1'b1 || words_done !== 16'd0) begin errors++; $display("FAIL timeout_final error=%b words_done=%0d expected 1/0", error, words_done); end
  endtask

  task automatic test_abort();
    int dc; logic [31:0] rt, wt;
    rdy_mode = 0; use_hash = 1'b1;
    run_copy(32'h1000, 32'h2000, 5, 2, 1'b0, dc, rt, wt);
    checks++; if (dc !== 4) begin errors++; $display("FAIL abort_done_cycle got %0d expected 4", dc); end
    checks++; if (rd_addr_q.size() !== 2 || wr_addr_q.size() !== 1) begin errors++; $display("FAIL abort_accesses reads=%0d writes=%0d expected 2/1", rd_addr_q.size(), wr_addr_q.size()); end
    checks++; if (words_done !== 16'd1 || error !== 1'b0) begin errors++; $display("FAIL abort_final words_done=%0d error=%b expected 1/0", words_done, error); end
  endtask

  task automatic test_boundary();
    int dc; logic [31:0] rt, wt;
    rdy_mode = 0; use_hash = 1'b1;
    run_copy(32'h1002, 32'h2000, 3, 0, 1'b0, dc, rt, wt);
    checks++; if (dc !== 1 || error !== 1'b1) begin errors++; $display("FAIL misaligned_src done_cycle=%0d error=%b expected 1/1", dc, error); end
    checks++; if ((rt | wt) !== 32'd0) begin errors++; $display("FAIL misaligned_bus_activity got %h expected 0", rt | wt); end
    run_copy(32'h1000, 32'h2000, 0, 0, 1'b0, dc, rt, wt);
    checks++; if (dc !== 1 || error !== 1'b0 || words_done !== 16'd0) begin errors++; $display("FAIL zero_count done_cycle=%0d error=%b words=%0d expected 1/0/0", dc, error, words_done); end
    run_copy(32'h1000, 32'h2001, 2, 0, 1'b0, dc, rt, wt);
    checks++; if (dc !== 1 || error !== 1'b1 || (rt | wt) !== 32'd0) begin errors++; $display("FAIL misaligned_dst done_cycle=%0d error=%b activity=%h expected 1/1/0", dc, error, rt | wt); end
    run_copy(32'hFFFF_FFFC, 32'h5000, 2, 0, 1'b0, dc, rt, wt);
    checks++; if (rd_addr_q.size() !== 2 || rd_addr_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_read reads=%0d second=%h expected 2/00000000", rd_addr_q.size(), (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hx); end
    checks++; if (wr_data_q.size() !== 2 || wr_data_q[1] !== src_word(32'h0)) begin errors++; $display("FAIL wrap_data writes=%0d expected data %h", wr_data_q.size(), src_word(32'h0)); end
  endtask

  task automatic test_reset_mid();
    int dc; logic [31:0] rt, wt;
    rdy_mode = 0; use_hash = 1'b1; seed = $urandom;
    @(negedge clk);
    src_addr = 32'h6000; dst_addr = 32'h7000; word_count = 16'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_wen !== 1'b1) begin errors++; $display("FAIL midreset_precondition wen=%b expected 1", bus_wen); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus_ren, bus_wen, bus_wmask, busy, done, error} !== 9'd0) begin errors++; $display("FAIL midreset_ctl got %b expected 0", {bus_ren, bus_wen, bus_wmask, busy, done, error}); end
    checks++; if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || words_done !== '0) begin errors++; $display("FAIL midreset_data addr=%h wdata=%h words=%0d expected 0", bus_addr, bus_wdata, words_done); end
    @(negedge clk); rst = 1'b0;
    run_copy(32'h6000, 32'h7000, 4, 0, 1'b0, dc, rt, wt);
    checks++; if (wr_addr_q.size() !== 4 || words_done !== 16'd4) begin errors++; $display("FAIL midreset_restart writes=%0d words=%0d expected 4/4", wr_addr_q.size(), words_done); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'h7000 + 32'(4 * i) || wr_data_q[i] !== src_word(32'h6000 + 32'(4 * i)))
        begin errors++; $display("FAIL midreset_write%0d got %h<=%h", i, wr_addr_q[i], wr_data_q[i]); end
    end
  endtask

  task automatic test_random();
    int dc, n; logic [31:0] rt, wt, s, d;
    bit rs;
    rdy_mode = 2; use_hash = 1'b1;
    for (int it = 0; it < 20; it++) begin
      seed = $urandom; viol = 0;
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      n = $urandom_range(1, 6);
      rs = 1'($urandom_range(0, 1));
      run_copy(s, d, n, 0, rs, dc, rt, wt);
      checks++; if (dc < 0) begin errors++; $display("FAIL rand%0d_timeout no done within bound", it); end
      checks++; if (words_done !== LEN_W'(n) || error !== 1'b0) begin errors++; $display("FAIL rand%0d_final words=%0d error=%b expected %0d/0", it, words_done, error, n); end
      checks++; if (wr_addr_q.size() !== n || rd_addr_q.size() !== n) begin errors++; $display("FAIL rand%0d_counts reads=%0d writes=%0d expected %0d", it, rd_addr_q.size(), wr_addr_q.size(), n); end
      for (int i = 0; i < n && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
        checks++; if (rd_addr_q[i] !== s + 32'(4 * i) || wr_addr_q[i] !== d + 32'(4 * i) || wr_data_q[i] !== src_word(s + 32'(4 * i)))
          begin errors++; $display("FAIL rand%0d_word%0d rd=%h wr=%h<=%h expected rd=%h wr=%h<=%h", it, i, rd_addr_q[i], wr_addr_q[i], wr_data_q[i], s + 32'(4 * i), d + 32'(4 * i), src_word(s + 32'(4 * i))); end
      end
      checks++; if (viol !== 0) begin errors++; $display("FAIL rand%0d_protocol got %0d violations expected 0", it, viol); end
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_abort();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dma_initiator.md
BUS_DMA_INITIATOR -- requirements
Module: bus_dma_initiator

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the word-count input.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for bus_ready per access; 0 disables the timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; launches a copy when idle.
REQ-006 src_addr  input  32  word-aligned source byte address.
REQ-007 dst_addr  input  32  word-aligned destination byte address.
REQ-008 word_count  input  LEN_W  number of 32-bit words to copy.
REQ-009 abort  input  1  level; stops the transfer at the next access boundary.
REQ-010 busy  output  1  high while a copy is in progress.
REQ-011 done  output  1  one-cycle pulse on completion, abort or error.
REQ-012 error  output  1  sticky timeout/misalignment flag; cleared by the next accepted start.
REQ-013 words_done  output  LEN_W  count of words written so far.
REQ-014 bus_addr  output  32  byte address of the current access; bits [1:0] always 0.
REQ-015 bus_wdata  output  32  write data.
REQ-016 bus_wmask  output  4  byte-lane enables; 4'b1111 during writes, 4'b0000 otherwise.
REQ-017 bus_wen  output  1  write request.
REQ-018 bus_ren  output  1  read request.
REQ-019 bus_rdata  input  32  read data from the responder.
REQ-020 bus_ready  input  1  access-complete qualifier; may be tied to 1 by responders.

Function
REQ-021 SHALL implement states IDLE, RD, WR, FIN.
- IDLE -> RD: start=1, word_count!=0, src_addr[1:0]==0, dst_addr[1:0]==0.
- IDLE -> FIN: start=1 with word_count==0 (error=0) or with misalignment (error=1).
REQ-022 SHALL latch src_addr, dst_addr and word_count on the accepting cycle; later input changes SHALL be ignored.
REQ-023 In RD, SHALL drive bus_ren=1 and bus_addr=current source address, both held stable until bus_ready=1.
REQ-024 On an RD edge with bus_ready=1, SHALL capture bus_rdata into a data register and go to WR.
REQ-025 In WR, SHALL drive bus_wen=1, bus_wmask=4'b1111, bus_addr=current destination address and bus_wdata=the data register, all held until bus_ready=1.
REQ-026 On a WR edge with bus_ready=1:
- increment words_done;
- advance both addresses by 4, wrapping modulo 2^32;
- go to FIN if words_done+1==word_count or abort=1, else to RD.
REQ-027 bus_ren and bus_wen SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and FIN.
REQ-028 Each access SHALL take at least one cycle; with bus_ready tied high, one word SHALL take exactly 2 cycles (RD, WR).
REQ-029 abort sampled in RD SHALL go to FIN without issuing the write; a read already in flight SHALL complete first (wait for bus_ready).
REQ-030 A wait counter SHALL reset on each RD/WR entry and count cycles with bus_ready=0.
- When it reaches TIMEOUT (TIMEOUT!=0): set error=1, drop the request, go to FIN.
REQ-031 FIN SHALL last one cycle, assert done=1, then return to IDLE.
REQ-032 busy SHALL be 1 in RD and WR, and 0 in IDLE and FIN.
REQ-033 start SHALL be ignored while busy=1 or in FIN.
REQ-034 words_done SHALL clear to 0 on an accepted start and hold its final value afterwards.

Reset
REQ-035 Asserting rst at any time, including mid-access, SHALL immediately force:
- state=IDLE;
- busy=0, done=0, error=0, words_done=0;
- bus_ren=0, bus_wen=0, bus_wmask=0, bus_addr=0, bus_wdata=0.
REQ-036 After rst deasserts, the first start SHALL be accepted normally; no partial transfer SHALL resume.

Verification
REQ-037 bus_ready tied 1, src=0x1000, dst=0x2000, count=3, source words 0xA,0xB,0xC:
- 6 bus cycles alternating read/write;
- writes land at 0x2000/0x2004/0x2008 with 0xA/0xB/0xC;
- done pulses on cycle 7; words_done=3; error=0.
REQ-038 bus_ready low for 2 cycles on every access, count=2:
- bus_addr and requests stay stable during each stall;
- completes in 12 cycles; data correct.
REQ-039 TIMEOUT=4, bus_ready stuck 0 on the first read:
- bus_ren held 4 cycles, then dropped;
- error=1, done pulses, words_done=0, no write issued.
REQ-040 count=5, abort raised during the 2nd RD:
- that read completes, no 2nd write;
- done pulses; words_done=1.
REQ-041 Boundary starts:
- start with src=0x1002 -> error=1, done next cycle, no bus activity;
- start with count=0 -> done next cycle, error=0;
- src=0xFFFFFFFC, count=2 -> second read at 0x00000000.
REQ-042 rst asserted mid-WR of a 4-word copy:
- bus_wen=0 immediately, all outputs at reset values;
- a new start after release copies from word 0.
